// File: rtl/gxsim_qspi_slave.sv
// Quad-SPI slave front-end: oversamples SCK/CS_N/DQ and bridges burst reads/writes to the register block.
// Optional GXSIM_QSPI_DEBUG_EN adds bad_cmd_count and last_cmd outputs.
module gxsim_qspi_slave #(
    parameter int unsigned DUMMY_CYCLES = 4,
    parameter logic [7:0]  CMD_WRITE    = 8'h02,
    parameter logic [7:0]  CMD_READ     = 8'h0B
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        qspi_sck,
    input  logic        qspi_cs_n,
    input  logic [3:0]  qspi_dq_in,
    output logic [3:0]  qspi_dq_out,
    output logic        qspi_dq_oe,
    output logic [31:0] address,
    output logic [31:0] wdata,
    output logic        write_strobe,
`ifdef GXSIM_QSPI_DEBUG_EN
    output logic [7:0]  bad_cmd_count,
    output logic [7:0]  last_cmd,
`endif
    input  logic [31:0] rdata
);

    localparam int unsigned CNT_W = (DUMMY_CYCLES > 8) ? $clog2(DUMMY_CYCLES + 1) : 4;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sck_s1_q, sck_s2_q, sck_prev_q;
    logic               cs_s1_q, cs_s2_q;
    logic [3:0]         dq_s1_q, dq_s2_q;
    logic               armed_q;
    logic               is_read_q;
    logic [3:0]         cmd_hi_q;
    logic [27:0]        addr_sh_q;
    logic [27:0]        data_sh_q;
    logic [27:0]        rd_sh_q;
    logic [3:0]         dq_out_q;
    logic               oe_q;
    logic [31:0]        address_q;
    logic [31:0]        wdata_q;
    logic               write_strobe_q;
`ifdef GXSIM_QSPI_DEBUG_EN
    logic [7:0]         bad_cmd_count_q;
    logic [7:0]         last_cmd_q;
`endif

    logic       rise_c;
    logic       fall_c;
    logic [7:0] cmd_byte_c;

    assign rise_c     = sck_s2_q & ~sck_prev_q;
    assign fall_c     = ~sck_s2_q & sck_prev_q;
    assign cmd_byte_c = {cmd_hi_q, dq_s2_q};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sck_s1_q       <= 1'b0;
            sck_s2_q       <= 1'b0;
            sck_prev_q     <= 1'b0;
            // CS synchronizer clears low so a CS_N already low at reset release is not treated as a new assertion
            cs_s1_q        <= 1'b0;
            cs_s2_q        <= 1'b0;
            dq_s1_q        <= 4'h0;
            dq_s2_q        <= 4'h0;
            armed_q        <= 1'b0;
            is_read_q      <= 1'b0;
            cmd_hi_q       <= 4'h0;
            addr_sh_q      <= '0;
            data_sh_q      <= '0;
            rd_sh_q        <= '0;
            dq_out_q       <= 4'h0;
            oe_q           <= 1'b0;
            address_q      <= '0;
            wdata_q        <= '0;
            write_strobe_q <= 1'b0;
`ifdef GXSIM_QSPI_DEBUG_EN
            bad_cmd_count_q <= 8'h00;
            last_cmd_q      <= 8'h00;
`endif
        end else begin
            sck_s1_q       <= qspi_sck;
            sck_s2_q       <= sck_s1_q;
            sck_prev_q     <= sck_s2_q;
            cs_s1_q        <= qspi_cs_n;
            cs_s2_q        <= cs_s1_q;
            dq_s1_q        <= qspi_dq_in;
            dq_s2_q        <= dq_s1_q;
            write_strobe_q <= 1'b0;

            if (write_strobe_q) begin
                address_q <= address_q + 32'd4;
            end

            // Deselect has priority over any SCK edge seen in the same cycle
            if (cs_s2_q) begin
                armed_q <= 1'b1;
                state_q <= IDLE;
                oe_q    <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        oe_q <= 1'b0;
                        if (armed_q) begin
                            state_q <= CMD;
                            cnt_q   <= '0;
                        end
                    end
                    CMD: if (rise_c) begin
                        cmd_hi_q <= dq_s2_q;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            cnt_q <= '0;
`ifdef GXSIM_QSPI_DEBUG_EN
                            last_cmd_q <= cmd_byte_c;
`endif
                            if (cmd_byte_c == CMD_WRITE) begin
                                is_read_q <= 1'b0;
                                state_q   <= ADDR;
                            end else if (cmd_byte_c == CMD_READ) begin
                                is_read_q <= 1'b1;
                                state_q   <= ADDR;
                            end else begin
                                state_q <= IGNORE;
`ifdef GXSIM_QSPI_DEBUG_EN
                                if (bad_cmd_count_q != 8'hFF) begin
                                    bad_cmd_count_q <= bad_cmd_count_q + 8'd1;
                                end
`endif
                            end
                        end
                    end
                    ADDR: if (rise_c) begin
                        addr_sh_q <= {addr_sh_q[23:0], dq_s2_q};
                        cnt_q     <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            address_q <= {addr_sh_q, dq_s2_q};
                            cnt_q     <= '0;
                            if (!is_read_q) begin
                                state_q <= WDATA;
                            end else if (DUMMY_CYCLES == 0) begin
                                state_q <= RDATA;
                                oe_q    <= 1'b1;
                            end else begin
                                state_q <= DUMMY;
                            end
                        end
                    end
                    WDATA: if (rise_c) begin
                        data_sh_q <= {data_sh_q[23:0], dq_s2_q};
                        cnt_q     <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            wdata_q        <= {data_sh_q, dq_s2_q};
                            write_strobe_q <= 1'b1;
                            cnt_q          <= '0;
                        end
                    end
                    DUMMY: if (rise_c) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                            state_q <= RDATA;
                            oe_q    <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                    RDATA: begin
                        oe_q <= 1'b1;
                        // First fall of each word reloads from the register block's current rdata
                        if (fall_c) begin
                            if (cnt_q == '0) begin
                                dq_out_q <= rdata[31:28];
                                rd_sh_q  <= rdata[27:0];
                            end else begin
                                dq_out_q <= rd_sh_q[27:24];
                                rd_sh_q  <= {rd_sh_q[23:0], 4'h0};
                            end
                        end
                        if (rise_c) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(7)) begin
                                cnt_q     <= '0;
                                address_q <= address_q + 32'd4;
                            end
                        end
                    end
                    IGNORE: oe_q <= 1'b0;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign qspi_dq_out  = dq_out_q;
    assign qspi_dq_oe   = oe_q;
    assign address      = address_q;
    assign wdata        = wdata_q;
    assign write_strobe = write_strobe_q;
`ifdef GXSIM_QSPI_DEBUG_EN
    assign bad_cmd_count = bad_cmd_count_q;
    assign last_cmd      = last_cmd_q;
`endif

endmodule

// File: tb/tb_gxsim_qspi_slave.sv
// Scoreboard bench for gxsim_qspi_slave: stimulus pushes expectations, one monitor process compares.
`timescale 1ns/1ps
module tb_gxsim_qspi_slave;

    logic        clk;
    logic        resetn;
    logic        qspi_sck;
    logic        qspi_cs_n;
    logic [3:0]  qspi_dq_in;
    logic [3:0]  qspi_dq_out;
    logic        qspi_dq_oe;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        write_strobe;
    logic [31:0] rdata;
`ifdef GXSIM_QSPI_DEBUG_EN
    logic [7:0]  bad_cmd_count;
    logic [7:0]  last_cmd;
`endif

    gxsim_qspi_slave dut (
        .clk          (clk),
        .resetn       (resetn),
        .qspi_sck     (qspi_sck),
        .qspi_cs_n    (qspi_cs_n),
        .qspi_dq_in   (qspi_dq_in),
        .qspi_dq_out  (qspi_dq_out),
        .qspi_dq_oe   (qspi_dq_oe),
        .address      (address),
        .wdata        (wdata),
        .write_strobe (write_strobe),
`ifdef GXSIM_QSPI_DEBUG_EN
        .bad_cmd_count(bad_cmd_count),
        .last_cmd     (last_cmd),
`endif
        .rdata        (rdata)
    );

    // Register-block stub
    assign rdata = 32'hCAFE_0000 | address;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] exp;
    } req_t;

    req_t        req_q[$];
    logic [63:0] wr_q[$];
    logic [3:0]  rd_q[$];

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned oe_bad = 0;
    logic        oe_allowed = 1'b0;
    logic        sck_last = 1'b0;

    function automatic string sel_name(input logic [3:0] sel);
        case (sel)
            4'd0: return "address";
            4'd1: return "wdata";
            4'd2: return "write_strobe";
            4'd3: return "dq_out";
            4'd4: return "dq_oe";
            4'd5: return "pending_strobes";
            4'd6: return "pending_read_nibbles";
            4'd7: return "oe_outside_read";
            4'd8: return "bad_cmd_count";
            default: return "last_cmd";
        endcase
    endfunction

    function automatic logic [31:0] actual(input logic [3:0] sel);
        case (sel)
            4'd0: return address;
            4'd1: return wdata;
            4'd2: return {31'd0, write_strobe};
            4'd3: return {28'd0, qspi_dq_out};
            4'd4: return {31'd0, qspi_dq_oe};
            4'd5: return 32'(wr_q.size());
            4'd6: return 32'(rd_q.size());
            4'd7: return oe_bad;
`ifdef GXSIM_QSPI_DEBUG_EN
            4'd8: return {24'd0, bad_cmd_count};
            4'd9: return {24'd0, last_cmd};
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: sole owner of the check/error counters
    always @(negedge clk) begin
        logic [63:0] we;
        logic [3:0]  rn;
        req_t        r;
        logic [31:0] act;
        if (qspi_dq_oe && !oe_allowed) oe_bad++;
        if (write_strobe) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got addr=%h wdata=%h, required no strobe", address, wdata);
            end else begin
                we = wr_q.pop_front();
                if ({address, wdata} !== we) begin
                    errors++;
                    $display("FAIL strobe: got addr=%h wdata=%h, required addr=%h wdata=%h",
                             address, wdata, we[63:32], we[31:0]);
                end
            end
        end
        if (qspi_sck && !sck_last && qspi_dq_oe) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read_nibble: got %h, required none", qspi_dq_out);
            end else begin
                rn = rd_q.pop_front();
                if (qspi_dq_out !== rn) begin
                    errors++;
                    $display("FAIL read_nibble: got %h, required %h", qspi_dq_out, rn);
                end
            end
        end
        sck_last = qspi_sck;
        while (req_q.size() > 0) begin
            r   = req_q.pop_front();
            act = actual(r.sel);
            checks++;
            if (act !== r.exp) begin
                errors++;
                $display("FAIL %s: got %h, required %h", sel_name(r.sel), act, r.exp);
            end
        end
    end

    task automatic req(input logic [3:0] sel, input logic [31:0] exp);
        req_q.push_back('{sel: sel, exp: exp});
        #10;
    endtask

    task automatic nib(input logic [3:0] n);
        qspi_sck   = 1'b0;
        qspi_dq_in = n;
        #50;
        qspi_sck   = 1'b1;
        #50;
    endtask

    task automatic word(input logic [31:0] w);
        for (int i = 7; i >= 0; i--) nib(w[i*4 +: 4]);
    endtask

    task automatic cs_begin();
        qspi_cs_n = 1'b0;
        #50;
    endtask

    task automatic cs_end();
        qspi_sck  = 1'b0;
        #50;
        qspi_cs_n = 1'b1;
        #100;
    endtask

    task automatic push_read_word(input logic [31:0] w);
        for (int i = 7; i >= 0; i--) rd_q.push_back(w[i*4 +: 4]);
    endtask

    task automatic check_reset_outputs();
        req(4'd0, 32'h0);
        req(4'd1, 32'h0);
        req(4'd2, 32'h0);
        req(4'd3, 32'h0);
        req(4'd4, 32'h0);
    endtask

    initial begin
        resetn     = 1'b0;
        qspi_sck   = 1'b0;
        qspi_cs_n  = 1'b1;
        qspi_dq_in = 4'h0;
        @(negedge clk);
        #2;
        #50;
        resetn = 1'b1;
        #50;
        check_reset_outputs();

        // Single write
        wr_q.push_back({32'h0000_0028, 32'h0000_0003});
        cs_begin(); nib(4'h0); nib(4'h2);
        word(32'h0000_0028); word(32'h0000_0003);
        cs_end();
        req(4'd0, 32'h0000_002C);

        // Burst write of two words
        wr_q.push_back({32'h0000_0000, 32'h1111_1111});
        wr_q.push_back({32'h0000_0004, 32'h2222_2222});
        cs_begin(); nib(4'h0); nib(4'h2);
        word(32'h0000_0000); word(32'h1111_1111); word(32'h2222_2222);
        cs_end();
        req(4'd0, 32'h0000_0008);

        // Burst read of two words after four dummy cycles
        push_read_word(32'hCAFE_0004);
        push_read_word(32'hCAFE_0008);
        cs_begin(); nib(4'h0); nib(4'hB);
        word(32'h0000_0004);
        nib(4'h0); nib(4'h0); nib(4'h0);
        oe_allowed = 1'b1;
        nib(4'h0);
        for (int i = 0; i < 16; i++) nib(4'h0);
        cs_end();
        oe_allowed = 1'b0;
        req(4'd4, 32'h0);
        req(4'd0, 32'h0000_000C);
        req(4'd6, 32'h0);

        // Write aborted after five data nibbles, then a normal write
        cs_begin(); nib(4'h0); nib(4'h2);
        word(32'h0000_0010);
        nib(4'h9); nib(4'h8); nib(4'h7); nib(4'h6); nib(4'h5);
        cs_end();
        req(4'd0, 32'h0000_0010);
        wr_q.push_back({32'h0000_0020, 32'hA5A5_A5A5});
        cs_begin(); nib(4'h0); nib(4'h2);
        word(32'h0000_0020); word(32'hA5A5_A5A5);
        cs_end();
        req(4'd0, 32'h0000_0024);

        // Unknown command followed by 16 nibbles
        cs_begin(); nib(4'h5); nib(4'h5);
        word(32'h0000_0000); word(32'hFFFF_FFFF);
        cs_end();
        req(4'd0, 32'h0000_0024);
`ifdef GXSIM_QSPI_DEBUG_EN
        req(4'd8, 32'h0000_0001);
        req(4'd9, 32'h0000_0055);
`endif

        // Reset mid-address with CS_N held low, then a decodable frame that must be ignored
        cs_begin(); nib(4'h0); nib(4'h2);
        nib(4'h0); nib(4'h0); nib(4'h0); nib(4'h0);
        resetn = 1'b0;
        #20;
        check_reset_outputs();
        resetn = 1'b1;
        #20;
        req(4'd0, 32'h0);
        nib(4'h0); nib(4'h2);
        word(32'h0000_0030); word(32'h1234_5678);
        cs_end();
        req(4'd0, 32'h0);
        wr_q.push_back({32'h0000_0040, 32'hDEAD_BEEF});
        cs_begin(); nib(4'h0); nib(4'h2);
        word(32'h0000_0040); word(32'hDEAD_BEEF);
        cs_end();
        req(4'd0, 32'h0000_0044);
`ifdef GXSIM_QSPI_DEBUG_EN
        req(4'd8, 32'h0);
        req(4'd9, 32'h0000_0002);
`endif

        req(4'd5, 32'h0);
        req(4'd6, 32'h0);
        req(4'd7, 32'h0);
        #50;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
